// File: rtl/lpm_table_access_arbiter_if.sv
// Bus bundle between the two table masters, the arbiter and the LPM route table
// register port. The arbiter takes the slave view; requesters/table models take master.
interface lpm_table_access_arbiter_if #(
  parameter int NUM_QUEUES     = 5,
  parameter int LUT_DEPTH_BITS = 5
);
  logic                      m0_req;
  logic                      m0_we;
  logic [LUT_DEPTH_BITS-1:0] m0_addr;
  logic [31:0]               m0_wr_ip;
  logic [31:0]               m0_wr_mask;
  logic [NUM_QUEUES-1:0]     m0_wr_oq;
  logic [31:0]               m0_wr_next_hop;
  logic                      m0_ack;
  logic                      m0_err;

  logic                      m1_req;
  logic                      m1_we;
  logic [LUT_DEPTH_BITS-1:0] m1_addr;
  logic [31:0]               m1_wr_ip;
  logic [31:0]               m1_wr_mask;
  logic [NUM_QUEUES-1:0]     m1_wr_oq;
  logic [31:0]               m1_wr_next_hop;
  logic                      m1_ack;
  logic                      m1_err;

  logic [31:0]               rd_ip;
  logic [31:0]               rd_mask;
  logic [31:0]               rd_next_hop;
  logic [NUM_QUEUES-1:0]     rd_oq;

  logic                      lpm_rd_req;
  logic                      lpm_wr_req;
  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr;
  logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr;
  logic [31:0]               lpm_wr_ip;
  logic [31:0]               lpm_wr_mask;
  logic [31:0]               lpm_wr_next_hop_ip;
  logic [NUM_QUEUES-1:0]     lpm_wr_oq;
  logic [31:0]               lpm_rd_ip;
  logic [31:0]               lpm_rd_mask;
  logic [31:0]               lpm_rd_next_hop_ip;
  logic [NUM_QUEUES-1:0]     lpm_rd_oq;
  logic                      lpm_rd_ack;
  logic                      lpm_wr_ack;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wr_ip, m0_wr_mask, m0_wr_oq, m0_wr_next_hop,
    input  m1_req, m1_we, m1_addr, m1_wr_ip, m1_wr_mask, m1_wr_oq, m1_wr_next_hop,
    output m0_ack, m0_err, m1_ack, m1_err,
    output rd_ip, rd_mask, rd_next_hop, rd_oq,
    output lpm_rd_req, lpm_wr_req, lpm_rd_addr, lpm_wr_addr,
    output lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    input  lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq,
    input  lpm_rd_ack, lpm_wr_ack
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wr_ip, m0_wr_mask, m0_wr_oq, m0_wr_next_hop,
    output m1_req, m1_we, m1_addr, m1_wr_ip, m1_wr_mask, m1_wr_oq, m1_wr_next_hop,
    input  m0_ack, m0_err, m1_ack, m1_err,
    input  rd_ip, rd_mask, rd_next_hop, rd_oq,
    input  lpm_rd_req, lpm_wr_req, lpm_rd_addr, lpm_wr_addr,
    input  lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    output lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq,
    output lpm_rd_ack, lpm_wr_ack
  );
endinterface

// File: rtl/lpm_table_access_arbiter.sv
// Round-robin arbiter sharing the LPM route table register port between the register
// block (m0) and the bulk route loader (m1). Optional WAIT timeout: LPM_ARB_TIMEOUT_EN.
module lpm_table_access_arbiter #(
  parameter int NUM_QUEUES     = 5,
  parameter int LUT_DEPTH_BITS = 5,
  parameter int TIMEOUT        = 1023
) (
  input logic                      clk,
  input logic                      reset,
  lpm_table_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state, state_next;
  logic                      grant, grant_next;  // 0 = m0, 1 = m1
  logic                      rr_ptr;             // preferred master on contention
  logic                      we_q;
  logic [LUT_DEPTH_BITS-1:0] addr_q;
  logic [31:0]               ip_q, mask_q, nh_q;
  logic [NUM_QUEUES-1:0]     oq_q;
  logic [31:0]               rd_ip_q, rd_mask_q, rd_nh_q;
  logic [NUM_QUEUES-1:0]     rd_oq_q;
  logic                      ack_match;
  logic                      timed_out;
  logic                      to_err;
  logic                      m0_ack, m1_ack, rd_req, wr_req;

`ifdef LPM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
  assign timed_out = (to_cnt == CNT_W'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timed_out      = 1'b0;
  assign to_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    ack_match  = we_q ? bus.lpm_wr_ack : bus.lpm_rd_ack;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant_next = (bus.m0_req && bus.m1_req) ? rr_ptr : bus.m1_req;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rd_req     = ~we_q;
        wr_req     = we_q;
        state_next = WAIT;
      end
      WAIT: begin
        if (ack_match || timed_out) state_next = DONE;
      end
      DONE: begin
        m0_ack     = ~grant;
        m1_ack     = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      ip_q      <= '0;
      mask_q    <= '0;
      nh_q      <= '0;
      oq_q      <= '0;
      rd_ip_q   <= '0;
      rd_mask_q <= '0;
      rd_nh_q   <= '0;
      rd_oq_q   <= '0;
    end else begin
      grant <= grant_next;
      if (state == IDLE && (bus.m0_req || bus.m1_req)) begin
        if (grant_next) begin
          we_q <= bus.m1_we;   addr_q <= bus.m1_addr;   ip_q <= bus.m1_wr_ip;
          mask_q <= bus.m1_wr_mask; nh_q <= bus.m1_wr_next_hop; oq_q <= bus.m1_wr_oq;
        end else begin
          we_q <= bus.m0_we;   addr_q <= bus.m0_addr;   ip_q <= bus.m0_wr_ip;
          mask_q <= bus.m0_wr_mask; nh_q <= bus.m0_wr_next_hop; oq_q <= bus.m0_wr_oq;
        end
      end
      // Only a read's own ack updates the read-result registers; stray acks do nothing.
      if (state == WAIT && !we_q && bus.lpm_rd_ack) begin
        rd_ip_q   <= bus.lpm_rd_ip;
        rd_mask_q <= bus.lpm_rd_mask;
        rd_nh_q   <= bus.lpm_rd_next_hop_ip;
        rd_oq_q   <= bus.lpm_rd_oq;
      end
      if (state == DONE) rr_ptr <= ~grant;
    end
  end

`ifdef LPM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state == WAIT && !ack_match) begin
      if (timed_out) to_err <= 1'b1;
      else           to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  assign bus.m0_ack             = m0_ack;
  assign bus.m1_ack             = m1_ack;
  assign bus.m0_err             = m0_ack & to_err;
  assign bus.m1_err             = m1_ack & to_err;
  assign bus.rd_ip              = rd_ip_q;
  assign bus.rd_mask            = rd_mask_q;
  assign bus.rd_next_hop        = rd_nh_q;
  assign bus.rd_oq              = rd_oq_q;
  assign bus.lpm_rd_req         = rd_req;
  assign bus.lpm_wr_req         = wr_req;
  assign bus.lpm_rd_addr        = addr_q;
  assign bus.lpm_wr_addr        = addr_q;
  assign bus.lpm_wr_ip          = ip_q;
  assign bus.lpm_wr_mask        = mask_q;
  assign bus.lpm_wr_next_hop_ip = nh_q;
  assign bus.lpm_wr_oq          = oq_q;

endmodule

// File: tb/tb_lpm_table_access_arbiter.sv
// Randomized bench for lpm_table_access_arbiter: two request generators, a table model
// with random latency and stray acks, mid-access resets, and a final silent-table phase.
module tb_lpm_table_access_arbiter;
  localparam int NQ = 5;
  localparam int AW = 5;
  localparam int TO = 15;

  typedef struct packed {
    logic [31:0]   ip;
    logic [31:0]   mask;
    logic [31:0]   nh;
    logic [NQ-1:0] oq;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lpm_table_access_arbiter_if #(.NUM_QUEUES(NQ), .LUT_DEPTH_BITS(AW)) bus ();

  lpm_table_access_arbiter #(.NUM_QUEUES(NQ), .LUT_DEPTH_BITS(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  entry_t         mem [2**AW];
  entry_t         rd_model, exp_rd, tbl_data;
  logic           req [2];
  logic           m_we [2];
  logic [AW-1:0]  m_addr [2];
  entry_t         m_data [2];
  bit             pending [2];
  bit             issued [2];
  int             starve [2];
  bit             busy, exp_to, tbl_wr, rst_prev, silent, stop_new;
  int             owner, last_served, ack_due, tbl_due, cyc;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic entry_t rd_out();
    return {bus.rd_ip, bus.rd_mask, bus.rd_next_hop, bus.rd_oq};
  endfunction

  function automatic entry_t wr_out();
    return {bus.lpm_wr_ip, bus.lpm_wr_mask, bus.lpm_wr_next_hop_ip, bus.lpm_wr_oq};
  endfunction

  task automatic zero_check(input string tag);
    check_eq({tag, "_ctl"}, {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.lpm_rd_req,
                             bus.lpm_wr_req, bus.lpm_rd_addr, bus.lpm_wr_addr}, '0);
    check_eq({tag, "_rd"}, rd_out(), '0);
    check_eq({tag, "_wr"}, wr_out(), '0);
  endtask

  task automatic apply_inputs();
    bus.m0_req = req[0]; bus.m0_we = m_we[0]; bus.m0_addr = m_addr[0];
    bus.m0_wr_ip = m_data[0].ip; bus.m0_wr_mask = m_data[0].mask;
    bus.m0_wr_next_hop = m_data[0].nh; bus.m0_wr_oq = m_data[0].oq;
    bus.m1_req = req[1]; bus.m1_we = m_we[1]; bus.m1_addr = m_addr[1];
    bus.m1_wr_ip = m_data[1].ip; bus.m1_wr_mask = m_data[1].mask;
    bus.m1_wr_next_hop = m_data[1].nh; bus.m1_wr_oq = m_data[1].oq;
  endtask

  // One clock of the reference: observe the cycle just begun, then drive its inputs.
  task automatic step();
    int  w, lat;
    bit  ackcyc, rst_now;
    bit  acked [2];
    entry_t rnd;

    if (rst_prev) begin
      zero_check("reset_mid");
      rst_prev = 1'b0;
    end

    // req[] still holds the levels of the previous cycle, which arbitration sampled.
    if (bus.lpm_rd_req || bus.lpm_wr_req) begin
      if (busy || !(req[0] || req[1])) begin
        check_eq("issue_allowed", {busy, req[0] | req[1]}, 2'b01);
      end else begin
        w = (req[0] && req[1]) ? ((last_served == 0) ? 1 : 0) : (req[0] ? 0 : 1);
        check_eq("issue_kind", {bus.lpm_wr_req, bus.lpm_rd_req}, m_we[w] ? 2'b10 : 2'b01);
        check_eq("issue_addr", m_we[w] ? bus.lpm_wr_addr : bus.lpm_rd_addr, m_addr[w]);
        if (m_we[w]) check_eq("issue_wdata", wr_out(), m_data[w]);
        busy = 1'b1; owner = w; issued[w] = 1'b1; last_served = w;
        exp_to = 1'b0;
        if (silent) begin
          tbl_due = -1;
          exp_rd  = rd_model;
`ifdef LPM_ARB_TIMEOUT_EN
          ack_due = cyc + TO + 2;
          exp_to  = 1'b1;
`else
          ack_due = -1;
`endif
        end else begin
          lat     = $urandom_range(1, 4);
          tbl_due = cyc + lat;
          ack_due = cyc + lat + 1;
          tbl_wr  = m_we[w];
          if (m_we[w]) begin
            mem[bus.lpm_wr_addr] = wr_out();
            exp_rd = rd_model;
          end else begin
            tbl_data = mem[bus.lpm_rd_addr];
            exp_rd   = mem[m_addr[w]];
          end
        end
      end
    end else if (busy) begin
      check_eq("hold_addr", m_we[owner] ? bus.lpm_wr_addr : bus.lpm_rd_addr, m_addr[owner]);
      if (m_we[owner]) check_eq("hold_wdata", wr_out(), m_data[owner]);
    end

    ackcyc   = busy && (cyc == ack_due);
    acked[0] = ackcyc && (owner == 0);
    acked[1] = ackcyc && (owner == 1);
    check_eq("m0_ack", bus.m0_ack, acked[0]);
    check_eq("m1_ack", bus.m1_ack, acked[1]);
    check_eq("m0_err", bus.m0_err, acked[0] && exp_to);
    check_eq("m1_err", bus.m1_err, acked[1] && exp_to);
    check_eq("rd_out", rd_out(), ackcyc ? exp_rd : rd_model);
    if (ackcyc) begin
      rd_model = exp_rd;
      busy = 1'b0;
      pending[owner] = 1'b0;
      issued[owner]  = 1'b0;
      req[owner]     = 1'b0;
    end

    for (int n = 0; n < 2; n++) begin
      if (!silent && pending[n] && !issued[n]) starve[n]++;
      else starve[n] = 0;
      if (starve[n] > 40) begin
        check_eq("starve", starve[n], 0);
        starve[n] = 0;
      end
    end

    rst_now = !silent && !stop_new && busy && ($urandom_range(0, 39) == 0);
    reset   = rst_now;
    if (rst_now) begin
      busy = 1'b0; ack_due = -1; last_served = 1; rd_model = '0; rst_prev = 1'b1;
      for (int n = 0; n < 2; n++) begin
        pending[n] = 1'b0; issued[n] = 1'b0; req[n] = 1'b0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (!pending[n] && !acked[n] && !stop_new && $urandom_range(0, 2) == 0) begin
          pending[n] = 1'b1;
          issued[n]  = 1'b0;
          req[n]     = 1'b1;
          m_we[n]    = 1'($urandom_range(0, 1));
          m_addr[n]  = AW'($urandom);
          m_data[n]  = {$urandom, $urandom, $urandom, NQ'($urandom)};
        end else if (pending[n] && issued[n] && $urandom_range(0, 7) == 0) begin
          req[n] = 1'b0;
        end
      end
    end

    rnd = {$urandom, $urandom, $urandom, NQ'($urandom)};
    bus.lpm_rd_ack = (tbl_due == cyc) && !tbl_wr;
    bus.lpm_wr_ack = (tbl_due == cyc) && tbl_wr;
    if (busy && tbl_due > cyc && $urandom_range(0, 3) == 0) begin
      if (tbl_wr) bus.lpm_rd_ack = 1'b1;
      else        bus.lpm_wr_ack = 1'b1;
    end
    if ((tbl_due == cyc) && !tbl_wr) rnd = tbl_data;
    {bus.lpm_rd_ip, bus.lpm_rd_mask, bus.lpm_rd_next_hop_ip, bus.lpm_rd_oq} = rnd;
    apply_inputs();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    step();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom, $urandom, NQ'($urandom)};
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; m_we[n] = 1'b0; m_addr[n] = '0; m_data[n] = '0;
      pending[n] = 1'b0; issued[n] = 1'b0; starve[n] = 0;
    end
    busy = 1'b0; exp_to = 1'b0; tbl_wr = 1'b0; rst_prev = 1'b0;
    silent = 1'b0; stop_new = 1'b0;
    owner = 0; last_served = 1; ack_due = -1; tbl_due = -1; cyc = 0;
    rd_model = '0; exp_rd = '0; tbl_data = '0;
    reset = 1'b1;
    bus.lpm_rd_ack = 1'b0; bus.lpm_wr_ack = 1'b0;
    {bus.lpm_rd_ip, bus.lpm_rd_mask, bus.lpm_rd_next_hop_ip, bus.lpm_rd_oq} = '0;
    apply_inputs();
    repeat (3) @(posedge clk);
    #1;
    zero_check("reset_state");
    reset = 1'b0;

    repeat (3000) next_cycle();

    stop_new = 1'b1;
    for (int i = 0; i < 200 && (busy || pending[0] || pending[1]); i++) next_cycle();
    check_eq("drain", {busy, pending[0], pending[1]}, 3'b000);

    silent   = 1'b1;
    stop_new = 1'b0;
    tbl_due  = -1;
    repeat (120) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
